instr_fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of decode.
- Owns the PC and drives the byte address of the program memory, which has a combinational 32-bit little-endian read port.
- Buffers fetched words with their PCs in a small FIFO and hands them to decode over a valid/ready handshake.
- Handles branch/jump redirects and halts on erased memory (0xFFFFFFFF).

---
 rtl/instr_fetch_unit.sv | 169 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads program memory and queues {pc, instr} pairs for decode.
// Build option FETCH_ALIGN_CHECK_EN: a misaligned redirect enters a sticky FAULT state instead of being aligned.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned ADDR_W   = 14,
   parameter int unsigned DEPTH    = 2
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [31:0]       out_pc,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_pc,
   output logic              halted,
   output logic              fetch_fault
);

   localparam int unsigned PTR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W       = $clog2(DEPTH + 1);
   localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
   localparam logic [31:0] ERASED_WORD = 32'hFFFF_FFFF;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_HALT = 2'd1
`ifdef FETCH_ALIGN_CHECK_EN
      , ST_FAULT = 2'd2
`endif
   } state_t;

   state_t             state_q, state_d;
   logic [31:0]        pc_q, pc_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               halted_q, halted_d;
   fetch_entry_t       mem_q [DEPTH];

   fetch_entry_t       head_c;
   fetch_entry_t       push_entry_c;
   logic               fifo_empty_c;
   logic               erased_c;
   logic               in_fault_c;
   logic               out_valid_c;
   logic               pop_c;
   logic               push_c;
   logic [31:0]        redirect_target_c;

   // Modulo-DEPTH pointer advance; DEPTH need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
      logic [PTR_W-1:0] nxt;
      if (ptr == PTR_W'(DEPTH - 1)) nxt = '0;
      else                           nxt = ptr + PTR_W'(1);
      return nxt;
   endfunction

   assign head_c            = mem_q[rd_ptr_q];
   assign push_entry_c      = '{pc: pc_q, instr: imem_rdata};
   assign fifo_empty_c      = (count_q == '0);
   assign erased_c          = (imem_rdata == ERASED_WORD);
   assign redirect_target_c = redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_ALIGN_CHECK_EN
   logic fault_q, fault_d;
   logic misaligned_c;
   assign in_fault_c   = (state_q == ST_FAULT);
   assign misaligned_c = (redirect_pc[1:0] != 2'b00);
   assign fetch_fault  = fault_q;
`else
   assign in_fault_c   = 1'b0;
   assign fetch_fault  = 1'b0;
`endif

   // A redirect hides the head entry in the same cycle so decode never takes a wrong-path word.
   assign out_valid_c = !fifo_empty_c && !redirect_valid && !in_fault_c;
   assign pop_c       = out_valid_c && out_ready;
   assign push_c      = (state_q == ST_RUN) && !redirect_valid && !erased_c &&
                        ((count_q < CNT_W'(DEPTH)) || pop_c);

   // Next-state logic for PC, FIFO bookkeeping and run/halt/fault state.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      halted_d = halted_q;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_d  = fault_q;
`endif
      if (redirect_valid && !in_fault_c) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         halted_d = 1'b0;
         state_d  = ST_RUN;
         pc_d     = redirect_target_c;
`ifdef FETCH_ALIGN_CHECK_EN
         if (misaligned_c) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
            pc_d    = pc_q;
         end
`endif
      end else begin
         if (pop_c) rd_ptr_d = ptr_inc(rd_ptr_q);
         if (push_c) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
            pc_d     = pc_q + 32'd4;
         end
         if (push_c && !pop_c)      count_d = count_q + CNT_W'(1);
         else if (!push_c && pop_c) count_d = count_q - CNT_W'(1);
         // Erased flash reads as all ones: stop fetching but let queued work drain.
         if ((state_q == ST_RUN) && !redirect_valid && erased_c) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_RUN;
         pc_q     <= RESET_PC;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         halted_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
         fault_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         halted_q <= halted_d;
`ifdef FETCH_ALIGN_CHECK_EN
         fault_q  <= fault_d;
`endif
      end
   end

   // Entry storage is a plain register array.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (push_c) begin
         mem_q[wr_ptr_q] <= push_entry_c;
      end
   end

   assign imem_addr = pc_q[ADDR_W-1:0];
   assign out_valid = out_valid_c;
   assign out_instr = fifo_empty_c ? NOP_INSTR : head_c.instr;
   assign out_pc    = fifo_empty_c ? 32'h0000_0000 : head_c.pc;
   assign halted    = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized traffic against a program-order model.
module tb_instr_fetch_unit;

   localparam int unsigned ADDR_W   = 14;
   localparam int unsigned DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int unsigned WORDS    = 1 << (ADDR_W - 2);

   logic              clk = 1'b0;
   logic              rst;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_rdata;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_instr;
   logic [31:0]       out_pc;
   logic              redirect_valid;
   logic [31:0]       redirect_pc;
   logic              halted;
   logic              fetch_fault;

   logic [31:0] mem [WORDS];
   logic [63:0] acc_q [$];
   int checks   = 0;
   int failures = 0;

   instr_fetch_unit #(.RESET_PC(RESET_PC), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .halted(halted), .fetch_fault(fetch_fault)
   );

   always #5 clk = ~clk;
   assign imem_rdata = mem[imem_addr[ADDR_W-1:2]];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] word_at(input logic [31:0] p);
      logic [ADDR_W-3:0] idx;
      idx = p[ADDR_W-1:2];
      return mem[idx];
   endfunction

   // One clock: record a decode handshake at the negedge, return 1 after the posedge.
   task automatic step();
      @(negedge clk);
      if (out_valid && out_ready) acc_q.push_back({out_pc, out_instr});
      @(posedge clk);
      #1;
   endtask

   task automatic wait_acc(input int n, input int budget, output bit ok);
      int k = 0;
      while (acc_q.size() < n && k < budget) begin
         step();
         k++;
      end
      ok = (acc_q.size() >= n);
   endtask

   task automatic do_reset();
      rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
      step(); step();
      rst = 1'b0;
      acc_q.delete();
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      checks++; if (out_instr !== 32'h0000_0013) begin failures++; $display("FAIL reset_instr got=%h exp=00000013", out_instr); end
      checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", out_pc); end
      checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
      checks++; if (fetch_fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b exp=0", fetch_fault); end
      checks++; if (imem_addr !== RESET_PC[ADDR_W-1:0]) begin failures++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, RESET_PC[ADDR_W-1:0]); end
   endtask

   task automatic test_stream();
      logic [31:0] p;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         p = 32'(i) * 32'd4;
         checks++;
         if (out_valid !== 1'b1 || out_pc !== p || out_instr !== word_at(p)) begin
            failures++;
            $display("FAIL stream_%0d got v=%b pc=%h instr=%h exp v=1 pc=%h instr=%h", i, out_valid, out_pc, out_instr, p, word_at(p));
         end
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      logic [31:0] p;
      do_reset();
      out_ready = 1'b0;
      repeat (5) step();
      checks++; if (imem_addr !== 14'h008) begin failures++; $display("FAIL bp_addr_hold got=%h exp=008", imem_addr); end
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin failures++; $display("FAIL bp_head got v=%b pc=%h exp v=1 pc=0", out_valid, out_pc); end
      out_ready = 1'b1;
      wait_acc(3, 10, ok);
      checks++; if (!ok) begin failures++; $display("FAIL bp_drain_timeout got=%0d exp=3", acc_q.size()); end
      for (int i = 0; i < 3 && i < acc_q.size(); i++) begin
         p = 32'(i) * 32'd4;
         checks++;
         if (acc_q[i] !== {p, word_at(p)}) begin
            failures++; $display("FAIL bp_order_%0d got=%h exp=%h", i, acc_q[i], {p, word_at(p)});
         end
      end
   endtask

   task automatic test_redirect();
      do_reset();
      out_ready = 1'b1;
      repeat (3) step();
      out_ready = 1'b0;
      repeat (2) step();
      checks++; if (out_pc !== 32'h8 || imem_addr !== 14'h010) begin failures++; $display("FAIL rd_setup got pc=%h addr=%h exp pc=8 addr=010", out_pc, imem_addr); end
      redirect_valid = 1'b1; redirect_pc = 32'h90; out_ready = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rd_valid_masked got=%b exp=0", out_valid); end
      step();
      redirect_valid = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rd_flushed got=%b exp=0", out_valid); end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h90 || out_instr !== word_at(32'h90)) begin
         failures++; $display("FAIL rd_new_path got v=%b pc=%h instr=%h exp v=1 pc=90 instr=%h", out_valid, out_pc, out_instr, word_at(32'h90));
      end
      step();
      checks++;
      if (acc_q.size() != 3 || acc_q[2][63:32] !== 32'h90) begin
         failures++; $display("FAIL rd_no_stale got n=%0d last=%h exp n=3 last=90", acc_q.size(), acc_q[acc_q.size()-1][63:32]);
      end
   endtask

   task automatic test_halt();
      bit ok;
      logic [31:0] p;
      do_reset();
      out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hF0;
      step();
      redirect_valid = 1'b0;
      wait_acc(5, 30, ok);
      checks++; if (!ok) begin failures++; $display("FAIL halt_drain_timeout got=%0d exp=5", acc_q.size()); end
      repeat (5) step();
      for (int i = 0; i < 5 && i < acc_q.size(); i++) begin
         p = 32'hF0 + 32'(i) * 32'd4;
         checks++;
         if (acc_q[i] !== {p, word_at(p)}) begin failures++; $display("FAIL halt_order_%0d got=%h exp=%h", i, acc_q[i], {p, word_at(p)}); end
      end
      checks++; if (acc_q.size() != 5) begin failures++; $display("FAIL halt_count got=%0d exp=5", acc_q.size()); end
      checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_flag got=%b exp=1", halted); end
      checks++; if (imem_addr !== 14'h104) begin failures++; $display("FAIL halt_addr got=%h exp=104", imem_addr); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL halt_empty got=%b exp=0", out_valid); end
      redirect_valid = 1'b1; redirect_pc = 32'h0;
      step();
      redirect_valid = 1'b0;
      checks++; if (halted !== 1'b0) begin failures++; $display("FAIL halt_clear got=%b exp=0", halted); end
      step();
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin failures++; $display("FAIL halt_restart got v=%b pc=%h exp v=1 pc=0", out_valid, out_pc); end
   endtask

   task automatic test_reset_redirect();
      do_reset();
      out_ready = 1'b0;
      repeat (3) step();
      rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
      step();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rr_valid got=%b exp=0", out_valid); end
      checks++; if (imem_addr !== RESET_PC[ADDR_W-1:0]) begin failures++; $display("FAIL rr_addr got=%h exp=%h", imem_addr, RESET_PC[ADDR_W-1:0]); end
      checks++; if (halted !== 1'b0) begin failures++; $display("FAIL rr_halted got=%b exp=0", halted); end
      rst = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
      step();
      checks++; if (out_valid !== 1'b1 || out_pc !== RESET_PC) begin failures++; $display("FAIL rr_first got v=%b pc=%h exp v=1 pc=%h", out_valid, out_pc, RESET_PC); end
   endtask

   task automatic test_wrap();
      bit ok;
      logic [31:0] p;
      logic [31:0] starts [2];
      int          lens   [2];
      starts[0] = 32'hFFFF_FFF8; lens[0] = 4;
      starts[1] = 32'h0000_3FFC; lens[1] = 2;
      for (int t = 0; t < 2; t++) begin
         do_reset();
         out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = starts[t];
         step();
         redirect_valid = 1'b0;
         wait_acc(lens[t], 20, ok);
         checks++; if (!ok) begin failures++; $display("FAIL wrap%0d_timeout got=%0d exp=%0d", t, acc_q.size(), lens[t]); end
         for (int i = 0; i < lens[t] && i < acc_q.size(); i++) begin
            p = starts[t] + 32'(i) * 32'd4;
            checks++;
            if (acc_q[i] !== {p, word_at(p)}) begin failures++; $display("FAIL wrap%0d_%0d got=%h exp=%h", t, i, acc_q[i], {p, word_at(p)}); end
         end
      end
   endtask

   task automatic test_align();
      do_reset();
      out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h92;
      step();
      redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      checks++; if (fetch_fault !== 1'b1 || halted !== 1'b0) begin failures++; $display("FAIL align_fault got f=%b h=%b exp f=1 h=0", fetch_fault, halted); end
      redirect_valid = 1'b1; redirect_pc = 32'h90;
      step();
      redirect_valid = 1'b0;
      step(); step();
      checks++; if (fetch_fault !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL align_sticky got f=%b v=%b exp f=1 v=0", fetch_fault, out_valid); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++; if (fetch_fault !== 1'b0) begin failures++; $display("FAIL align_rst got=%b exp=0", fetch_fault); end
`else
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h90 || out_instr !== word_at(32'h90) || fetch_fault !== 1'b0) begin
         failures++; $display("FAIL align_clear got v=%b pc=%h f=%b exp v=1 pc=90 f=0", out_valid, out_pc, fetch_fault);
      end
`endif
   endtask

   // Randomized ready/redirect traffic; every accepted entry must follow program order from the last target.
   task automatic test_random();
      logic [31:0] exp_pc, tgt;
      logic [63:0] got;
      int accepted = 0;
      do_reset();
      exp_pc = RESET_PC;
      for (int cyc = 0; cyc < 600; cyc++) begin
         out_ready      = ($urandom_range(0, 3) != 0);
         redirect_valid = ($urandom_range(0, 24) == 0);
         tgt            = 32'($urandom_range(0, WORDS - 1)) << 2;
         redirect_pc    = tgt;
         #1;
         if (redirect_valid) begin
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rnd_mask_%0d got=%b exp=0", cyc, out_valid); end
            exp_pc = tgt;
         end
         step();
         while (acc_q.size() > 0) begin
            got = acc_q.pop_front();
            accepted++;
            checks++;
            if (word_at(exp_pc) == 32'hFFFF_FFFF || got !== {exp_pc, word_at(exp_pc)}) begin
               failures++; $display("FAIL rnd_entry_%0d got=%h exp=%h", cyc, got, {exp_pc, word_at(exp_pc)});
            end
            exp_pc = exp_pc + 32'd4;
         end
      end
      redirect_valid = 1'b0;
      checks++; if (accepted < 100) begin failures++; $display("FAIL rnd_progress got=%0d exp>=100", accepted); end
   endtask

   initial begin
      logic [31:0] w;
      rst = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      for (int i = 0; i < WORDS; i++) begin
         do w = $urandom; while (w == 32'hFFFF_FFFF);
         mem[i] = w;
      end
      mem[0] = 32'h0000_10B7;
      mem[1] = 32'h0080_8093;
      mem[2] = 32'h000F_F137;
      mem[3] = 32'h0AB1_0113;
      mem[32'h104 >> 2] = 32'hFFFF_FFFF;

      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_halt();
      test_reset_redirect();
      test_wrap();
      test_align();
      test_random();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
